ca_code_gen_bank: RTL and testbench
===================================

Name: ca_code_gen_bank

Overview:
- Eight-channel GPS C/A PRN code generator sitting directly downstream of the NCO bank.
- Consumes the per-channel 1.023 MHz chip-clock square waves, which are the MSBs of the code NCOs, packed as an 8-bit bus.
- Advances a G1/G2 Gold-code LFSR pair on each chip-clock rising edge.
- Outputs per-channel code bits and 1 ms epoch pulses for the modulator and DAC path.

Parameters:
- NUM_CH, 8, number of channels; must match the NCO bank width.
- TAP_W, 4, width of each G2 phase-selector tap index.
- CHIP_LEN, 1023, chips per code period; chip counter wraps at CHIP_LEN-1.

Ports:
- clk  input  1  system clock, same clock as the NCO bank.
- rst  input  1  synchronous reset, active-high.
- clk_1023k  input  NUM_CH  per-channel chip-clock square wave; bit i belongs to channel i.
- ch_en  input  NUM_CH  per-channel run enable.
- ch_load  input  NUM_CH  per-channel single-cycle load strobe.
- tap_a  input  NUM_CH*TAP_W  G2 tap index A per channel; channel i occupies [i*TAP_W +: TAP_W].
- tap_b  input  NUM_CH*TAP_W  G2 tap index B per channel, same packing as tap_a.
- code_out  output  NUM_CH  current C/A chip per channel.
- epoch  output  NUM_CH  one-cycle pulse when the channel wraps from chip 1022 to chip 0.
- chip_idx  output  NUM_CH*10  current chip number per channel, range 0..1022.

Behaviour:
- Channel state, per channel:
  - clk_d: 1-bit delayed copy of clk_1023k[i].
  - g1[1:10] and g2[1:10]: LFSR registers.
  - ta and tb: latched tap indices.
  - cnt: 10-bit chip counter.
- Chip advance (adv):
  - adv = clk_1023k[i] & ~clk_d & ch_en[i].
  - clk_d updates every cycle regardless of ch_en. Asserting ch_en therefore never creates a spurious edge.
- LFSR step on adv:
  - g1 shifts with feedback g1[3]^g1[10].
  - g2 shifts with feedback g2[2]^g2[3]^g2[6]^g2[8]^g2[9]^g2[10].
  - cnt increments.
- Wrap: on adv with cnt==CHIP_LEN-1:
  - cnt goes to 0.
  - g1 and g2 are forced to all ones, independent of natural periodicity.
  - epoch[i] is 1 in the next cycle only.
- Code bit:
  - code_out[i] = g1[10] ^ (G2(ta) ^ G2(tb)).
  - G2(k) = g2[k] for k in 1..10. G2(k) = 0 for k==0 or k>10 (invalid index contributes nothing).
  - code_out is a function of registered state only; there is no combinational path from any input.
- Latency:
  - clk_1023k[i] rises in cycle n; adv is true in cycle n.
  - New state, code_out, chip_idx and epoch are visible from cycle n+1.
  - Chip-clock high or low phases shorter than 1 clk are not supported.
- Load: ch_load[i] in cycle n:
  - ta/tb latch tap_a/tap_b.
  - g1 and g2 are forced to all ones; cnt is forced to 0.
  - No epoch pulse.
  - Takes effect in n+1 and takes priority over a simultaneous adv, which is dropped.
- ch_en low: state holds; code_out holds its last value; epoch stays 0.
- Reset, synchronous in the cycle rst is high:
  - ta=2 and tb=6 (PRN 1); g1=g2=all ones; cnt=0; clk_d=0.
  - Outputs: code_out=8'hFF (g1[10]=1, g2[2]^g2[6]=0), epoch=0, chip_idx=0.
  - Reset overrides load and adv.
  - Reset mid-code discards the current phase.
- Channels are fully independent; no shared state.

Optional Feature:
- Macro: CA_NAV_BIT_EN.
- Defined:
  - Adds output nav_edge [NUM_CH] and a per-channel 5-bit epoch counter, range 0..19.
  - The counter increments on each wrap. nav_edge[i] pulses for one cycle, coincident with epoch[i], when the counter wraps 19 to 0. This marks the 20 ms nav-bit boundary.
  - Load or reset clears the counter to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, default taps, ch_en=FF, chip clock at 1/8 clk rate -> first 10 code_out[0] chips 1,1,0,0,1,0,0,0,0,0 (octal 1440, PRN 1).
- ch_load[1] with tap_a=3, tap_b=7, then run -> first 10 chips of channel 1 are 1110010000 (octal 1620, PRN 2).
- Run 1023 rising edges -> epoch pulses exactly one cycle, one cycle after the 1023rd edge; chip_idx returns to 0; the next 10 chips repeat the pattern from scenario 1.
- ch_load coincident with a rising edge at chip 500 -> chip_idx=0 and no epoch in the next cycle; the code restarts from chip 0 pattern.
- ch_en low with clk_1023k high, then ch_en high while clk_1023k stays high -> no advance; the first advance occurs on the next 0->1 transition.
- tap_a=0, tap_b=11 -> code_out equals g1[10] alone, i.e. first 10 chips 1111111111.
- With CA_NAV_BIT_EN: 20 full periods -> nav_edge pulses once, together with the 20th epoch.

Source files
------------

// File: rtl/ca_code_gen_bank_if.sv
// Bus bundle for the eight-channel C/A code generator bank.
// Optional macro CA_NAV_BIT_EN adds the nav_edge output.
interface ca_code_gen_bank_if #(
   parameter int NUM_CH = 8,
   parameter int TAP_W  = 4
);
   logic [NUM_CH-1:0]       clk_1023k;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH-1:0]       ch_load;
   logic [NUM_CH*TAP_W-1:0] tap_a;
   logic [NUM_CH*TAP_W-1:0] tap_b;
   logic [NUM_CH-1:0]       code_out;
   logic [NUM_CH-1:0]       epoch;
   logic [NUM_CH*10-1:0]    chip_idx;
`ifdef CA_NAV_BIT_EN
   logic [NUM_CH-1:0]       nav_edge;
`endif

   modport master (
      output clk_1023k, ch_en, ch_load, tap_a, tap_b,
`ifdef CA_NAV_BIT_EN
      input  nav_edge,
`endif
      input  code_out, epoch, chip_idx
   );

   modport slave (
      input  clk_1023k, ch_en, ch_load, tap_a, tap_b,
`ifdef CA_NAV_BIT_EN
      output nav_edge,
`endif
      output code_out, epoch, chip_idx
   );
endinterface

// File: rtl/ca_code_gen_bank.sv
// Eight independent GPS C/A Gold-code generators clocked by NCO chip-clock edges.
// Optional macro CA_NAV_BIT_EN adds a 20-epoch nav-bit boundary pulse per channel.
module ca_code_gen_bank #(
   parameter int NUM_CH   = 8,
   parameter int TAP_W    = 4,
   parameter int CHIP_LEN = 1023
) (
   input  logic               clk,
   input  logic               rst,
   ca_code_gen_bank_if.slave  bus
);
   localparam logic [9:0] CNT_LAST = 10'(CHIP_LEN - 1);

   logic [NUM_CH-1:0] clk_d;
   logic [NUM_CH-1:0] epoch_r;
   logic [NUM_CH-1:0] adv;
   logic [1:10]       g1 [NUM_CH];
   logic [1:10]       g2 [NUM_CH];
   logic [TAP_W-1:0]  ta [NUM_CH];
   logic [TAP_W-1:0]  tb [NUM_CH];
   logic [9:0]        cnt [NUM_CH];
`ifdef CA_NAV_BIT_EN
   logic [4:0]        ep_cnt [NUM_CH];
   logic [NUM_CH-1:0] nav_r;
`endif

   // clk_d follows the chip clock even while disabled, so enabling mid-high-phase sees no edge.
   assign adv = bus.clk_1023k & ~clk_d & bus.ch_en;

   // Tap indices outside 1..10 select nothing.
   function automatic logic g2_tap(input logic [1:10] g2v, input logic [TAP_W-1:0] k);
      logic r;
      r = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         if (int'(k) == j) r = g2v[j];
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            clk_d[i]   <= 1'b0;
            epoch_r[i] <= 1'b0;
            ta[i]      <= TAP_W'(2);
            tb[i]      <= TAP_W'(6);
            g1[i]      <= '1;
            g2[i]      <= '1;
            cnt[i]     <= '0;
`ifdef CA_NAV_BIT_EN
            ep_cnt[i]  <= '0;
            nav_r[i]   <= 1'b0;
`endif
         end else begin
            clk_d[i]   <= bus.clk_1023k[i];
            epoch_r[i] <= 1'b0;
`ifdef CA_NAV_BIT_EN
            nav_r[i]   <= 1'b0;
`endif
            if (bus.ch_load[i]) begin
               ta[i]     <= bus.tap_a[i*TAP_W +: TAP_W];
               tb[i]     <= bus.tap_b[i*TAP_W +: TAP_W];
               g1[i]     <= '1;
               g2[i]     <= '1;
               cnt[i]    <= '0;
`ifdef CA_NAV_BIT_EN
               ep_cnt[i] <= '0;
`endif
            end else if (adv[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  // Re-seed on wrap rather than trusting the LFSR's natural period.
                  cnt[i]     <= '0;
                  g1[i]      <= '1;
                  g2[i]      <= '1;
                  epoch_r[i] <= 1'b1;
`ifdef CA_NAV_BIT_EN
                  if (ep_cnt[i] == 5'd19) begin
                     ep_cnt[i] <= '0;
                     nav_r[i]  <= 1'b1;
                  end else begin
                     ep_cnt[i] <= ep_cnt[i] + 5'd1;
                  end
`endif
               end else begin
                  cnt[i] <= cnt[i] + 10'd1;
                  g1[i]  <= {g1[i][3] ^ g1[i][10], g1[i][1:9]};
                  g2[i]  <= {g2[i][2] ^ g2[i][3] ^ g2[i][6] ^ g2[i][8] ^ g2[i][9] ^ g2[i][10],
                            g2[i][1:9]};
               end
            end
         end
      end
   end

   always_comb begin
      bus.code_out = '0;
      bus.chip_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bus.code_out[i]          = g1[i][10] ^ g2_tap(g2[i], ta[i]) ^ g2_tap(g2[i], tb[i]);
         bus.chip_idx[i*10 +: 10] = cnt[i];
      end
   end

   assign bus.epoch = epoch_r;
`ifdef CA_NAV_BIT_EN
   assign bus.nav_edge = nav_r;
`endif
endmodule

// File: tb/tb_ca_code_gen_bank.sv
// Bench for ca_code_gen_bank: chip-index reference model plus fixed PRN pattern checks.
module tb_ca_code_gen_bank;
   localparam int NUM_CH   = 8;
   localparam int TAP_W    = 4;
   localparam int CHIP_LEN = 1023;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ca_code_gen_bank_if #(.NUM_CH(NUM_CH), .TAP_W(TAP_W)) bus ();
   ca_code_gen_bank #(.NUM_CH(NUM_CH), .TAP_W(TAP_W), .CHIP_LEN(CHIP_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic                    drv_rst;
   logic [NUM_CH-1:0]       drv_clk, drv_en, drv_load;
   logic [NUM_CH*TAP_W-1:0] drv_ta, drv_tb;

   // Reference model: chip index per channel and code tables indexed by chip number.
   bit        g1_out [CHIP_LEN];
   bit [10:1] g2_tab [CHIP_LEN];
   int        m_idx [NUM_CH];
   int        m_ta [NUM_CH];
   int        m_tb [NUM_CH];
   int        m_ecnt [NUM_CH];
   bit        m_prev [NUM_CH];
   bit        m_epoch [NUM_CH];
   bit        m_nav [NUM_CH];

   int    bad_cycles;
   string first_bad;
   int    ep0_seen, nav0_seen, ep_at_nav;

   function automatic void build_tables();
      bit [10:1] s1, s2;
      s1 = '1;
      s2 = '1;
      for (int k = 0; k < CHIP_LEN; k++) begin
         g1_out[k] = s1[10];
         g2_tab[k] = s2;
         s1 = {s1[9:1], s1[3] ^ s1[10]};
         s2 = {s2[9:1], s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10]};
      end
   endfunction

   function automatic bit exp_code(input int ch);
      bit r;
      r = g1_out[m_idx[ch]];
      if (m_ta[ch] >= 1 && m_ta[ch] <= 10) r ^= g2_tab[m_idx[ch]][m_ta[ch]];
      if (m_tb[ch] >= 1 && m_tb[ch] <= 10) r ^= g2_tab[m_idx[ch]][m_tb[ch]];
      return r;
   endfunction

   function automatic void model_step();
      bit adv;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_epoch[ch] = 1'b0;
         m_nav[ch]   = 1'b0;
         if (drv_rst) begin
            m_ta[ch] = 2; m_tb[ch] = 6; m_idx[ch] = 0; m_prev[ch] = 1'b0; m_ecnt[ch] = 0;
         end else begin
            adv = drv_clk[ch] && !m_prev[ch] && drv_en[ch];
            m_prev[ch] = drv_clk[ch];
            if (drv_load[ch]) begin
               m_ta[ch] = int'(drv_ta[ch*TAP_W +: TAP_W]);
               m_tb[ch] = int'(drv_tb[ch*TAP_W +: TAP_W]);
               m_idx[ch] = 0;
               m_ecnt[ch] = 0;
            end else if (adv) begin
               if (m_idx[ch] == CHIP_LEN - 1) begin
                  m_idx[ch] = 0;
                  m_epoch[ch] = 1'b1;
                  m_ecnt[ch]++;
                  if (m_ecnt[ch] == 20) begin
                     m_ecnt[ch] = 0;
                     m_nav[ch] = 1'b1;
                  end
               end else begin
                  m_idx[ch]++;
               end
            end
         end
      end
   endfunction

   task automatic tick();
      @(negedge clk);
      rst           = drv_rst;
      bus.clk_1023k = drv_clk;
      bus.ch_en     = drv_en;
      bus.ch_load   = drv_load;
      bus.tap_a     = drv_ta;
      bus.tap_b     = drv_tb;
      @(posedge clk);
      model_step();
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         logic [9:0] ci;
         logic       bad;
         ci  = bus.chip_idx[ch*10 +: 10];
         bad = (bus.code_out[ch] !== exp_code(ch)) || (ci !== 10'(m_idx[ch])) ||
               (bus.epoch[ch] !== m_epoch[ch]);
`ifdef CA_NAV_BIT_EN
         bad = bad || (bus.nav_edge[ch] !== m_nav[ch]);
`endif
         if (bad) begin
            bad_cycles++;
            if (bad_cycles == 1)
               first_bad = $sformatf("t=%0t ch%0d code=%b/%b idx=%0d/%0d epoch=%b/%b",
                  $time, ch, bus.code_out[ch], exp_code(ch), ci, m_idx[ch], bus.epoch[ch], m_epoch[ch]);
         end
      end
      if (bus.epoch[0] === 1'b1) ep0_seen++;
`ifdef CA_NAV_BIT_EN
      if (bus.nav_edge[0] === 1'b1) begin
         nav0_seen++;
         ep_at_nav = ep0_seen;
      end
`endif
   endtask

   task automatic chip_period(input int half);
      drv_clk = '0;
      repeat (half) tick();
      drv_clk = '1;
      repeat (half) tick();
   endtask

   task automatic load_ch(input int ch, input int a, input int b);
      drv_load[ch] = 1'b1;
      drv_ta[ch*TAP_W +: TAP_W] = TAP_W'(a);
      drv_tb[ch*TAP_W +: TAP_W] = TAP_W'(b);
      tick();
      drv_load = '0;
   endtask

   // First chip is MSB, matching the octal notation of the ICD.
   task automatic run_chips(input int ch, input int half, output logic [9:0] bits);
      bits[9] = bus.code_out[ch];
      for (int k = 1; k < 10; k++) begin
         chip_period(half);
         bits[9-k] = bus.code_out[ch];
      end
   endtask

   task automatic start_test();
      bad_cycles = 0;
      first_bad  = "";
   endtask

   task automatic end_test(input string name);
      checks++;
      if (bad_cycles !== 0) begin
         errors++;
         $display("FAIL %s_model bad_cycles=%0d required 0 first: %s", name, bad_cycles, first_bad);
      end
   endtask

   task automatic test_reset();
      start_test();
      drv_rst = 1'b1;
      drv_en  = '1;
      tick();
      tick();
      checks++;
      if (bus.code_out !== 8'hFF) begin errors++; $display("FAIL reset_code got %h required ff", bus.code_out); end
      checks++;
      if (bus.epoch !== 8'h00) begin errors++; $display("FAIL reset_epoch got %h required 00", bus.epoch); end
      checks++;
      if (bus.chip_idx !== '0) begin errors++; $display("FAIL reset_chip_idx got %h required 0", bus.chip_idx); end
      drv_rst = 1'b0;
      tick();
      end_test("reset");
   endtask

   task automatic test_prn1();
      logic [9:0] bits;
      start_test();
      run_chips(0, 4, bits);
      checks++;
      if (bits !== 10'b1100100000) begin errors++; $display("FAIL prn1_chips got %b required 1100100000", bits); end
      end_test("prn1");
   endtask

   task automatic test_load_prn2();
      logic [9:0] bits;
      start_test();
      load_ch(1, 3, 7);
      run_chips(1, 4, bits);
      checks++;
      if (bits !== 10'b1110010000) begin errors++; $display("FAIL prn2_chips got %b required 1110010000", bits); end
      end_test("prn2");
   endtask

   task automatic test_wrap();
      logic [9:0] bits;
      start_test();
      drv_clk = '0;
      load_ch(0, 2, 6);
      ep0_seen = 0;
      repeat (CHIP_LEN - 1) chip_period(1);
      checks++;
      if (ep0_seen !== 0 || bus.chip_idx[9:0] !== 10'd1022) begin
         errors++; $display("FAIL wrap_pre epochs=%0d idx=%0d required 0 and 1022", ep0_seen, bus.chip_idx[9:0]);
      end
      drv_clk = '0;
      tick();
      drv_clk = '1;
      tick();
      checks++;
      if (bus.epoch[0] !== 1'b1 || bus.chip_idx[9:0] !== 10'd0) begin
         errors++; $display("FAIL wrap_epoch epoch=%b idx=%0d required 1 and 0", bus.epoch[0], bus.chip_idx[9:0]);
      end
      tick();
      checks++;
      if (bus.epoch[0] !== 1'b0 || ep0_seen !== 1) begin
         errors++; $display("FAIL wrap_pulse_width epoch=%b count=%0d required 0 and 1", bus.epoch[0], ep0_seen);
      end
      run_chips(0, 4, bits);
      checks++;
      if (bits !== 10'b1100100000) begin errors++; $display("FAIL wrap_repeat got %b required 1100100000", bits); end
      end_test("wrap");
   endtask

   task automatic test_load_mid();
      logic [9:0] bits;
      start_test();
      drv_clk = '0;
      load_ch(0, 2, 6);
      repeat (500) chip_period(1);
      drv_clk = '0;
      tick();
      ep0_seen = 0;
      drv_clk = '1;
      load_ch(0, 2, 6);
      checks++;
      if (bus.chip_idx[9:0] !== 10'd0 || bus.epoch[0] !== 1'b0) begin
         errors++; $display("FAIL load_mid idx=%0d epoch=%b required 0 and 0", bus.chip_idx[9:0], bus.epoch[0]);
      end
      run_chips(0, 4, bits);
      checks++;
      if (bits !== 10'b1100100000 || ep0_seen !== 0) begin
         errors++; $display("FAIL load_mid_restart got %b epochs=%0d required 1100100000 and 0", bits, ep0_seen);
      end
      end_test("load_mid");
   endtask

   task automatic test_enable();
      int start;
      start_test();
      drv_clk = '0;
      tick();
      start = m_idx[0];
      drv_en[0] = 1'b0;
      drv_clk = '1;
      repeat (3) tick();
      drv_en[0] = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus.chip_idx[9:0] !== 10'(start)) begin
         errors++; $display("FAIL enable_no_edge idx=%0d required %0d", bus.chip_idx[9:0], start);
      end
      drv_clk = '0;
      tick();
      drv_clk = '1;
      tick();
      checks++;
      if (bus.chip_idx[9:0] !== 10'((start + 1) % CHIP_LEN)) begin
         errors++; $display("FAIL enable_next_edge idx=%0d required %0d", bus.chip_idx[9:0], (start + 1) % CHIP_LEN);
      end
      end_test("enable");
   endtask

   task automatic test_invalid_taps();
      logic [9:0] bits2, bits3;
      start_test();
      drv_clk = '0;
      drv_load[3] = 1'b1;
      drv_ta[3*TAP_W +: TAP_W] = 4'd15;
      drv_tb[3*TAP_W +: TAP_W] = 4'd0;
      load_ch(2, 0, 11);
      bits3[9] = bus.code_out[3];
      run_chips(2, 4, bits2);
      checks++;
      if (bits2 !== 10'b1111111111) begin errors++; $display("FAIL taps_0_11 got %b required 1111111111", bits2); end
      checks++;
      if (bus.code_out[3] !== 1'b1 || bits3[9] !== 1'b1) begin
         errors++; $display("FAIL taps_15_0 got %b/%b required 1/1", bits3[9], bus.code_out[3]);
      end
      end_test("invalid_taps");
   endtask

   task automatic test_random();
      start_test();
      for (int n = 0; n < 3000; n++) begin
         drv_clk  = NUM_CH'($urandom);
         drv_en   = NUM_CH'($urandom | $urandom);
         drv_load = ($urandom_range(0, 15) == 0) ? NUM_CH'(1 << $urandom_range(0, NUM_CH - 1)) : '0;
         drv_ta   = (NUM_CH*TAP_W)'($urandom);
         drv_tb   = (NUM_CH*TAP_W)'($urandom);
         drv_rst  = (n == 1500);
         tick();
      end
      drv_rst  = 1'b0;
      drv_load = '0;
      drv_en   = '1;
      end_test("random");
   endtask

`ifdef CA_NAV_BIT_EN
   task automatic test_nav();
      start_test();
      drv_clk = '0;
      load_ch(0, 2, 6);
      ep0_seen = 0; nav0_seen = 0; ep_at_nav = 0;
      repeat (20 * CHIP_LEN) chip_period(1);
      repeat (2) tick();
      checks++;
      if (nav0_seen !== 1 || ep_at_nav !== 20 || ep0_seen !== 20) begin
         errors++; $display("FAIL nav_edge pulses=%0d at_epoch=%0d epochs=%0d required 1, 20, 20",
                            nav0_seen, ep_at_nav, ep0_seen);
      end
      end_test("nav");
   endtask
`endif

   initial begin
      build_tables();
      drv_rst = 1'b1; drv_clk = '0; drv_en = '1; drv_load = '0; drv_ta = '0; drv_tb = '0;
      rst = 1'b1;
      bus.clk_1023k = '0; bus.ch_en = '1; bus.ch_load = '0; bus.tap_a = '0; bus.tap_b = '0;
      ep0_seen = 0; nav0_seen = 0; ep_at_nav = 0;
      test_reset();
      test_prn1();
      test_load_prn2();
      test_wrap();
      test_load_mid();
      test_enable();
      test_invalid_taps();
      test_random();
`ifdef CA_NAV_BIT_EN
      test_nav();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
